// File: rtl/i2c_slave.sv
// Oversampled I2C target: synchronizes SCL/SDA, decodes START/STOP, ACKs SLAVE_ADDR,
// delivers written bytes on rx_data/rx_valid and fetches read bytes via tx_req/tx_data.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   rise, fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic [7:0] shift_in;

    // Synchronizers and previous-value flops reset to 1 so an idle bus produces no events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign rise      = scl_s & ~scl_prev_q;
    assign fall      = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign shift_in  = {shift_q[6:0], sda_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = shift_in[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // bit_cnt 8 -> ACK not yet driven, 9 -> ACK on the bus.
                ST_ADDR_ACK: begin
                    if (rise && bit_cnt_q == 4'd9 && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd9;
                    end else if (fall && bit_cnt_q == 4'd9) begin
                        if (rw_q) begin
                            shift_d   = {tx_data[6:0], 1'b0};
                            sda_oe_d  = ~tx_data[7];
                            bit_cnt_d = 4'd1;
                            state_d   = ST_READ;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: if (rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd9;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WRITE;
                    end
                end
                // shift_q holds the not-yet-driven bits left-aligned; count 0 means load pending.
                ST_READ: if (fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        shift_d   = {tx_data[6:0], 1'b0};
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 4'd1;
                    end else if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_READ_ACK;
                    end else begin
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                ST_READ_ACK: if (rise) begin
                    if (!sda_s) begin
                        tx_req_d  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_READ;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 200;  // quarter SCL period: 20 system clocks

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int unsigned rx_cnt = 0, tx_cnt = 0, rx_wide = 0, oe_cnt = 0;
    logic [7:0]  rx_log [0:31];
    logic        rxv_prev = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[4:0]] = rx_data;
            rx_cnt++;
        end
        if (rx_valid && rxv_prev) rx_wide++;
        rxv_prev = rx_valid;
        if (tx_req) tx_cnt++;
        if (sda_oe) oe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    // next_tx is presented after the 8 data bits, before the ACK/NACK clock.
    task automatic recv_byte(input logic [7:0] next_tx, input logic ack_in, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        tx_data = next_tx;
        write_bit(ack_in);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ack;
        logic [7:0]  rd;
        int unsigned rx0, tx0, oe0;

        reset_n = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'h00;
        #100;
        check_eq("rst_sda_oe", sda_oe, 1'b0);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_tx_req", tx_req, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        #(4*Q);

        // Write 0xA5, 0x3C to 0x50
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("w_addr_ack", ack, 1'b0);
        check_eq("w_busy", busy, 1'b1);
        send_byte(8'hA5, ack); check_eq("w_d0_ack", ack, 1'b0);
        send_byte(8'h3C, ack); check_eq("w_d1_ack", ack, 1'b0);
        check_eq("w_rx_cnt", rx_cnt - rx0, 2);
        check_eq("w_rx0", rx_log[rx0[4:0]], 8'hA5);
        check_eq("w_rx1", rx_log[rx0[4:0] + 5'd1], 8'h3C);
        check_eq("w_busy_pre_stop", busy, 1'b1);
        i2c_stop();
        #Q;
        check_eq("w_busy_stop", busy, 1'b0);
        check_eq("w_rx_width", rx_wide, 0);

        // Wrong address 0x51
        rx0 = rx_cnt; oe0 = oe_cnt;
        i2c_start();
        send_byte(8'hA2, ack); check_eq("na_addr_nack", ack, 1'b1);
        send_byte(8'h55, ack); check_eq("na_data_nack", ack, 1'b1);
        check_eq("na_busy", busy, 1'b0);
        i2c_stop();
        #Q;
        check_eq("na_oe_cycles", oe_cnt - oe0, 0);
        check_eq("na_rx_cnt", rx_cnt - rx0, 0);

        // Read 0x96 (ACK), 0x0F (NACK)
        tx0 = tx_cnt;
        tx_data = 8'h96;
        i2c_start();
        send_byte(8'hA1, ack); check_eq("r_addr_ack", ack, 1'b0);
        recv_byte(8'h0F, 1'b0, rd); check_eq("r_byte0", rd, 8'h96);
        recv_byte(8'h00, 1'b1, rd); check_eq("r_byte1", rd, 8'h0F);
        check_eq("r_oe_after_nack", sda_oe, 1'b0);
        check_eq("r_busy_after_nack", busy, 1'b0);
        check_eq("r_tx_req_cnt", tx_cnt - tx0, 2);
        i2c_stop();
        #Q;

        // Write 0x11, repeated START, read 0xC3
        rx0 = rx_cnt;
        tx_data = 8'hC3;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("rs_waddr_ack", ack, 1'b0);
        send_byte(8'h11, ack); check_eq("rs_wdata_ack", ack, 1'b0);
        check_eq("rs_rx_data", rx_data, 8'h11);
        check_eq("rs_busy_pre", busy, 1'b1);
        i2c_start();
        check_eq("rs_busy_restart", busy, 1'b0);
        send_byte(8'hA1, ack); check_eq("rs_raddr_ack", ack, 1'b0);
        recv_byte(8'h00, 1'b1, rd); check_eq("rs_rdata", rd, 8'hC3);
        i2c_stop();
        #Q;
        check_eq("rs_rx_cnt", rx_cnt - rx0, 1);

        // STOP after 4 data bits
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("ps_addr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        #Q;
        check_eq("ps_rx_cnt", rx_cnt - rx0, 0);
        check_eq("ps_busy", busy, 1'b0);
        check_eq("ps_oe", sda_oe, 1'b0);
        i2c_start();
        send_byte(8'hA0, ack); check_eq("ps2_addr_ack", ack, 1'b0);
        send_byte(8'h5A, ack); check_eq("ps2_data_ack", ack, 1'b0);
        i2c_stop();
        #Q;
        check_eq("ps2_rx_cnt", rx_cnt - rx0, 1);
        check_eq("ps2_rx_data", rx_data, 8'h5A);

        // Reset while the target drives a 0 read bit
        tx_data = 8'h00;
        i2c_start();
        send_byte(8'hA1, ack); check_eq("rr_addr_ack", ack, 1'b0);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        check_eq("rr_oe_driving", sda_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rr_oe_async", sda_oe, 1'b0);
        #(Q-1);
        scl_m = 1'b0; #Q;
        reset_n = 1'b1;
        #Q;
        rx0 = rx_cnt; oe0 = oe_cnt;
        send_byte(8'hA0, ack); check_eq("rr_nostart_nack", ack, 1'b1);
        send_byte(8'h33, ack); check_eq("rr_nostart_data_nack", ack, 1'b1);
        check_eq("rr_busy", busy, 1'b0);
        check_eq("rr_oe_cycles", oe_cnt - oe0, 0);
        check_eq("rr_rx_cnt", rx_cnt - rx0, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, ack); check_eq("rr2_addr_ack", ack, 1'b0);
        send_byte(8'h77, ack); check_eq("rr2_data_ack", ack, 1'b0);
        i2c_stop();
        #Q;
        check_eq("rr2_rx_cnt", rx_cnt - rx0, 1);
        check_eq("rr2_rx_data", rx_data, 8'h77);
        check_eq("final_rx_width", rx_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Oversampled I2C target (responder) that answers the bus master on a 7-bit address. Runs on the system clock, samples the SCL and SDA pins through synchronizers, decodes START and STOP, and acknowledges its address. Write bytes are delivered to local logic as received bytes. Read bytes are fetched from local logic through a request/data handshake. SDA is driven open-drain only: the block pulls low or releases.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target responds to.
- `SYNC_STAGES`, default 2: flop stages on `scl_i` and `sda_i`, minimum 2.
- `clk` in, 1: system clock; must be at least 10x the SCL frequency.
- `reset_n` in, 1: asynchronous active-low reset.
- `scl_i` in, 1: SCL pin, asynchronous.
- `sda_i` in, 1: SDA pin, asynchronous.
- `sda_oe` out, 1: 1 pulls SDA low; 0 releases it (pull-up gives 1).
- `rx_data` out, 8: last byte written by the master.
- `rx_valid` out, 1: one-clk pulse when `rx_data` updates.
- `tx_req` out, 1: one-clk pulse requesting the next read byte.
- `tx_data` in, 8: read byte; sampled at the first SCL-fall detect after `tx_req`.
- `busy` out, 1: high while this target is addressed.

## Operation
- The synchronizer flops and the previous-value flops reset to 1 (idle bus). All events are derived from synchronized values:
  - rise: SCL 0 to 1.
  - fall: SCL 1 to 0.
  - START: SDA 1 to 0 while SCL is high.
  - STOP: SDA 0 to 1 while SCL is high.
- States:
  - IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
  - IGNORE means "not addressed or transfer ended"; wait for START/STOP.
- START, from any state: go to ADDR, clear the bit counter, set `sda_oe`=0 and `busy`=0. This gives repeated-start support.
- STOP, from any state: go to IDLE, set `sda_oe`=0 and `busy`=0.
- START/STOP have priority over rise/fall detected in the same clk.
- ADDR:
  - Shift `sda` in MSB first on each rise.
  - On the 8th rise, if bits[7:1] == `SLAVE_ADDR` go to ADDR_ACK and set `busy`=1. Otherwise go to IGNORE.
  - Bit 0 is latched as `rw`.
- ADDR_ACK:
  - At the fall ending bit 8, set `sda_oe`=1.
  - If `rw`=1, pulse `tx_req` at the 9th rise.
  - At the next fall:
    - `rw`=0: release SDA and go to WRITE.
    - `rw`=1: load `tx_data` into the shift register, drive its MSB (`sda_oe`=~bit), and go to READ.
- WRITE:
  - Shift on rise.
  - On the 8th rise, update `rx_data` and pulse `rx_valid`, then go to WRITE_ACK.
  - At the next fall set `sda_oe`=1 (always ACK).
  - At the following fall release SDA and return to WRITE with the counter cleared.
- READ:
  - On each fall drive the next bit as `sda_oe`=~bit.
  - After the 8th bit's fall, release SDA and go to READ_ACK.
- READ_ACK, sampling SDA at the 9th rise:
  - 0 (ACK): pulse `tx_req`, go to READ, and load `tx_data` at the next fall.
  - 1 (NACK): go to IGNORE, set `busy`=0, keep SDA released.
- Bit counter is 4 bits, cleared on START and on every byte boundary; no wrap beyond 9.
- Reset values: state IDLE; `sda_oe`, `rx_valid`, `tx_req`, `busy` = 0; `rx_data` = 8'h00.
- `reset_n` asserted mid-transfer releases SDA immediately (asynchronous). After reset, no byte is accepted until a fresh START.

## Timing
- Pin-to-event latency is `SYNC_STAGES`+1 clk (3 at default).
- `sda_oe` changes within 1 clk of fall detection, i.e. `SYNC_STAGES`+2 clk after the pin SCL falls. The SCL low time must exceed this plus setup.
- `rx_valid` asserts `SYNC_STAGES`+2 clk after the 8th SCL rise on the pin; it is exactly 1 clk wide.
- `tx_req` asserts at the 9th rise detect. `tx_data` must be stable from the clk after `tx_req` until the next fall detect, at least half an SCL period.
- No clock stretching: SCL is never driven.
- SDA changes while SCL is high, other than START/STOP, cannot originate from this block, because all drive changes follow fall detection.

## Test plan
- Write to 0x50 (addr byte 0xA0), data 0xA5 then 0x3C, STOP:
  - ACK low on both 9th clocks.
  - `rx_valid` pulses twice, with `rx_data`=0xA5 then 0x3C.
  - `busy` falls at STOP.
- Address 0x51 write: `sda_oe` stays 0 throughout; no `rx_valid`; `busy`=0.
- Read from 0x50 (0xA1) with `tx_data`=0x96, master ACK, next `tx_data`=0x0F, master NACK, STOP:
  - Bus carries 0x96 then 0x0F.
  - `tx_req` pulses exactly twice.
  - SDA is released after the NACK.
- Write 0x50 byte 0x11, repeated START, read 0x50 with `tx_data`=0xC3:
  - `rx_data`=0x11.
  - Read returns 0xC3.
  - State re-enters ADDR at the repeated START.
- STOP after 4 data bits of a write: no `rx_valid`; state IDLE; `sda_oe`=0; the next full transaction works normally.
- `reset_n` low while driving a read 0 bit: `sda_oe` drops to 0 asynchronously. Data bits sent after release are ignored until the next START.
